// File: rtl/flappy_game_ctrl.sv
// flappy_game_ctrl: frame-rate Flappy Bird sequencer (bird physics, two pipes, collision, score, IDLE/PLAY/DEAD)
//   in : clk (pixel clock), reset (async, active-low), flap (debounced button level), vCount (vertical counter)
//   out: BirdX/BirdY (bird centre), PipeX1/PipeX2 (pipe centre X), PipeY1/PipeY2 (gap top), score, game_state
module flappy_game_ctrl #(
    parameter int GRAVITY       = 1,
    parameter int FLAP_VEL      = -6,
    parameter int VMAX          = 8,
    parameter int PIPE_SPEED    = 2,
    parameter int PIPE_START    = 944,
    parameter int PIPE_END      = 94,
    parameter int PIPE_GAP_BASE = 100,
    parameter int DEAD_HOLD     = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       flap,
    input  logic [9:0] vCount,
    output logic [9:0] BirdX,
    output logic [9:0] BirdY,
    output logic [9:0] PipeX1,
    output logic [9:0] PipeX2,
    output logic [9:0] PipeY1,
    output logic [9:0] PipeY2,
    output logic [7:0] score,
    output logic [1:0] game_state
);
    typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, DEAD = 2'd2} state_t;
    localparam logic signed [5:0] GRAV = 6'(GRAVITY);
    localparam logic signed [5:0] FVEL = 6'(FLAP_VEL);
    localparam logic signed [5:0] VLIM = 6'(VMAX);
    localparam logic [9:0] P_SPD    = 10'(PIPE_SPEED);
    localparam logic [9:0] P_START  = 10'(PIPE_START);
    localparam logic [9:0] P_END    = 10'(PIPE_END);
    localparam logic [9:0] P_BASE   = 10'(PIPE_GAP_BASE);
    localparam logic [5:0] HOLD     = 6'(DEAD_HOLD);
    localparam logic [9:0] BIRD_X   = 10'd300;
    localparam logic [9:0] Y_INIT   = 10'd275;
    localparam logic [9:0] GAP_INIT = 10'd200;
    localparam logic [9:0] Y_MIN    = 10'd45;
    localparam logic [9:0] Y_MAX    = 10'd504;
    localparam logic [9:0] P2_REL   = 10'd544;
    state_t state_q, state_d;
    logic [9:0] vcount_q, vcount_d, lfsr_q, lfsr_d;
    logic flap_q, flap_d, flap_pend_q, flap_pend_d, p2_q, p2_d;
    logic signed [5:0] vel_q, vel_d, vel_up, vel_n;
    logic [9:0] bird_y_q, bird_y_d, bird_y_n;
    logic [9:0] x1_q, x1_d, x1_n, y1_q, y1_d, y1_n;
    logic [9:0] x2_q, x2_d, x2_n, y2_q, y2_d, y2_n;
    logic [7:0] score_q, score_d, score_n;
    logic [5:0] dead_cnt_q, dead_cnt_d;
    logic signed [10:0] y_sum;
    logic [8:0] sc_sum;
    logic tick, cross1, cross2, hit;
    // Pipe column (X +-50) overlaps bird box (X +-10) and the bird is outside the open gap
    function automatic logic pipe_hit(input logic [9:0] px, input logic [9:0] py, input logic [9:0] by);
        logic signed [10:0] dx, b, p;
        dx = 11'sd300 - $signed({1'b0, px});
        b  = $signed({1'b0, by});
        p  = $signed({1'b0, py});
        return dx >= -11'sd60 && dx <= 11'sd60 && (b - 11'sd10 <= p || b + 11'sd10 >= p + 11'sd100);
    endfunction
    always_comb begin
        vcount_d    = vCount;
        flap_d      = flap;
        tick        = vCount == 10'd0 && vcount_q != 10'd0;
        flap_pend_d = (flap_pend_q && !tick) || (flap && !flap_q);
        lfsr_d      = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
        vel_up      = vel_q + GRAV;
        vel_n       = flap_pend_q ? FVEL : (vel_up > VLIM ? VLIM : vel_up);
        y_sum       = $signed({1'b0, bird_y_q}) + $signed({{5{vel_n[5]}}, vel_n});
        bird_y_n    = y_sum < 11'sd45 ? Y_MIN : (y_sum > 11'sd504 ? Y_MAX : y_sum[9:0]);
        x1_n        = x1_q <= P_END ? P_START : x1_q - P_SPD;
        y1_n        = x1_q <= P_END ? P_BASE + {2'b00, lfsr_q[7:0]} : y1_q;
        x2_n        = !p2_q ? P_START : (x2_q <= P_END ? P_START : x2_q - P_SPD);
        y2_n        = p2_q && x2_q <= P_END ? P_BASE + {2'b00, lfsr_q[7:0]} : y2_q;
        cross1      = x1_q > BIRD_X && x1_n <= BIRD_X;
        cross2      = p2_q && x2_q > BIRD_X && x2_n <= BIRD_X;
        sc_sum      = {1'b0, score_q} + {8'd0, cross1} + {8'd0, cross2};
        score_n     = sc_sum[8] ? 8'hFF : sc_sum[7:0];
        hit         = bird_y_q == Y_MIN || bird_y_q == Y_MAX ||
                      pipe_hit(x1_q, y1_q, bird_y_q) || pipe_hit(x2_q, y2_q, bird_y_q);
        state_d     = state_q;
        vel_d       = vel_q;
        bird_y_d    = bird_y_q;
        x1_d        = x1_q;
        y1_d        = y1_q;
        x2_d        = x2_q;
        y2_d        = y2_q;
        score_d     = score_q;
        p2_d        = p2_q;
        dead_cnt_d  = dead_cnt_q;
        case (state_q)
            IDLE: if (tick && flap_pend_q) begin
                state_d = PLAY;
                vel_d   = FVEL;
            end
            PLAY: if (hit) begin
                state_d = DEAD;
            end else if (tick) begin
                vel_d    = vel_n;
                bird_y_d = bird_y_n;
                x1_d     = x1_n;
                y1_d     = y1_n;
                x2_d     = x2_n;
                y2_d     = y2_n;
                score_d  = score_n;
                p2_d     = p2_q || x1_n == P2_REL;
            end
            DEAD: if (tick && flap_pend_q && dead_cnt_q == HOLD) begin
                state_d    = IDLE;
                vel_d      = '0;
                bird_y_d   = Y_INIT;
                x1_d       = P_START;
                x2_d       = P_START;
                y1_d       = GAP_INIT;
                y2_d       = GAP_INIT;
                score_d    = '0;
                p2_d       = 1'b0;
                dead_cnt_d = '0;
            end else if (tick) begin
                dead_cnt_d = dead_cnt_q == HOLD ? HOLD : dead_cnt_q + 6'd1;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vcount_q    <= '0;
            flap_q      <= 1'b0;
            flap_pend_q <= 1'b0;
            lfsr_q      <= 10'h1;
            state_q     <= IDLE;
            vel_q       <= '0;
            bird_y_q    <= Y_INIT;
            x1_q        <= P_START;
            x2_q        <= P_START;
            y1_q        <= GAP_INIT;
            y2_q        <= GAP_INIT;
            score_q     <= '0;
            p2_q        <= 1'b0;
            dead_cnt_q  <= '0;
        end else begin
            vcount_q    <= vcount_d;
            flap_q      <= flap_d;
            flap_pend_q <= flap_pend_d;
            lfsr_q      <= lfsr_d;
            state_q     <= state_d;
            vel_q       <= vel_d;
            bird_y_q    <= bird_y_d;
            x1_q        <= x1_d;
            x2_q        <= x2_d;
            y1_q        <= y1_d;
            y2_q        <= y2_d;
            score_q     <= score_d;
            p2_q        <= p2_d;
            dead_cnt_q  <= dead_cnt_d;
        end
    end
    assign BirdX      = BIRD_X;
    assign BirdY      = bird_y_q;
    assign PipeX1     = x1_q;
    assign PipeX2     = x2_q;
    assign PipeY1     = y1_q;
    assign PipeY2     = y2_q;
    assign score      = score_q;
    assign game_state = state_q;
endmodule
